sdram_port_scheduler: RTL

- Burst scheduler for the 4-port SDRAM controller.
- Watches fill levels of the two write FIFOs (WR1, WR2) and two read FIFOs (RD1, RD2) and picks one eligible port by round-robin.
- Issues one burst command (address, length, direction) to the SDRAM command engine, with refresh at highest priority.
- Keeps a per-port address pointer that wraps at the port's maximum address.
- Port index: 0=WR1, 1=WR2, 2=RD1, 3=RD2.

---
 rtl/sdram_port_scheduler_if.sv | 24 ++
 rtl/sdram_port_scheduler.sv | 103 ++++++++++
 2 files changed

// File: rtl/sdram_port_scheduler_if.sv
// sdram_port_scheduler_if: burst command and refresh handshake between scheduler and SDRAM engine
interface sdram_port_scheduler_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 9
);
    logic              ref_req;
    logic              ref_done;
    logic              ref_grant;
    logic              cmd_req;
    logic              cmd_ack;
    logic              cmd_done;
    logic              cmd_wr;
    logic [1:0]        cmd_port;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    modport master (
        input  ref_req, ref_done, cmd_ack, cmd_done,
        output ref_grant, cmd_req, cmd_wr, cmd_port, cmd_addr, cmd_len
    );
    modport slave (
        output ref_req, ref_done, cmd_ack, cmd_done,
        input  ref_grant, cmd_req, cmd_wr, cmd_port, cmd_addr, cmd_len
    );
endinterface

// File: rtl/sdram_port_scheduler.sv
// sdram_port_scheduler: round-robin burst scheduler for 2 write + 2 read FIFO ports with refresh priority
module sdram_port_scheduler #(
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 9,
    parameter int USE_W      = 10,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          port_en,
    input  logic [3:0]          port_load,
    input  logic [4*USE_W-1:0]  port_use,
    input  logic [4*LEN_W-1:0]  port_len,
    input  logic [4*ADDR_W-1:0] port_base,
    input  logic [4*ADDR_W-1:0] port_max,
    sdram_port_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, BUSY, REF} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] base [4];
    logic [ADDR_W-1:0] addr_max [4];
    logic [ADDR_W-1:0] offset [4];
    logic [LEN_W-1:0]  len [4];
    logic [3:0]        elig;
    logic [1:0]        last_grant, win, port_q;
    logic              kill, done, wrap, wr_q;
    logic [ADDR_W:0]   next_off;
    logic [ADDR_W+1:0] next_end;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;

    genvar g;
    for (g = 0; g < 4; g++) begin : g_port
        logic [USE_W:0] use_x, len_x;
        assign base[g]     = port_base[g*ADDR_W +: ADDR_W];
        assign addr_max[g] = port_max[g*ADDR_W +: ADDR_W];
        assign len[g]      = port_len[g*LEN_W +: LEN_W];
        assign use_x       = {1'b0, port_use[g*USE_W +: USE_W]};
        assign len_x       = (USE_W+1)'(len[g]);
        // writes need a full burst buffered; reads need room for a full burst
        assign elig[g] = port_en[g] && len[g] != '0 && !port_load[g] &&
                         (g < 2 ? use_x >= len_x : use_x + len_x <= (USE_W+1)'(FIFO_DEPTH));
    end

    always_comb begin
        win = last_grant;
        for (int i = 3; i >= 0; i--)
            if (elig[2'(last_grant + 2'(i + 1))]) win = 2'(last_grant + 2'(i + 1));
    end

    assign done     = bus.cmd_done && (state == BUSY || (state == REQ && bus.cmd_ack));
    assign next_off = {1'b0, offset[port_q]} + (ADDR_W+1)'(len_q);
    assign next_end = {1'b0, base[port_q]} + {1'b0, next_off};
    assign wrap     = next_end >= {2'b0, addr_max[port_q]};

    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = bus.ref_req ? REF : (|elig ? REQ : IDLE);
        else if (state == REQ && bus.cmd_ack) state_nx = bus.cmd_done ? IDLE : BUSY;
        else if (state == BUSY && bus.cmd_done) state_nx = IDLE;
        else if (state == REF && bus.ref_done) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            kill       <= 1'b0;
            port_q     <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
        end else begin
            state <= state_nx;
            // a load seen while the port is in flight cancels its done-time advance
            kill  <= state == IDLE ? 1'b0 : kill | port_load[port_q];
            if (done) last_grant <= port_q;
            if (state == IDLE && !bus.ref_req && |elig) begin
                port_q <= win;
                wr_q   <= !win[1];
                addr_q <= base[win] + offset[win];
                len_q  <= len[win];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) offset[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (port_load[i]) offset[i] <= '0;
                else if (done && !kill && port_q == 2'(i)) offset[i] <= wrap ? '0 : next_off[ADDR_W-1:0];
        end
    end

    assign bus.cmd_req   = state == REQ;
    assign bus.ref_grant = state == REF;
    assign bus.cmd_port  = port_q;
    assign bus.cmd_wr    = wr_q;
    assign bus.cmd_addr  = addr_q;
    assign bus.cmd_len   = len_q;
endmodule
